mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the CPU data port, beside the data ram.
//  CPU stores to TXDATA push bytes into a small FIFO. A serializer drains
//  the FIFO onto tx as 8N1 frames. Firmware polls STATUS through a
//  combinational read, with the same timing as the ram read path.
// PARAMETERS
//  BASE_ADDR     32'h0000_1000  byte address of TXDATA; STATUS is at BASE_ADDR+4
//  CLKS_PER_BIT  4              clk cycles per serial bit, >=2 (sim value; silicon sets baud)
//  FIFO_DEPTH    4              byte entries, power of two, >=2
// PORTS
//  clk    in   1   system clock, rising edge
//  reset  in   1   synchronous, active-high reset
//  addr   in   32  CPU data address (dataAddr)
//  wdata  in   32  CPU store data (writeData); only [7:0] used for TXDATA
//  we     in   1   CPU store strobe
//  hit    out  1   comb: addr==BASE_ADDR or addr==BASE_ADDR+4; top gates ram we with !hit
//  rdata  out  32  comb: STATUS word when addr==BASE_ADDR+4, else 0
//  tx     out  1   serial line, idle high
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset (sampled at clk edge):
//   - FIFO empty, count=0, state IDLE, baud and bit counters 0.
//   - overflow=0, tx=1.
//  STATUS word fields:
//   - [0]=busy (state!=IDLE), [1]=full, [2]=empty, [3]=overflow.
//   - [7:4]=count, saturating at 15; [31:8]=0.
//  Push:
//   - Condition: we && addr==BASE_ADDR at an edge pushes wdata[7:0].
//   - Rejected when full, except in the same cycle as a pop.
//   - A rejected push sets overflow (sticky).
//  Overflow clear: we && addr==BASE_ADDR+4 clears overflow; the data is ignored.
//  Pop: at an edge where state==IDLE && !empty, pop the head byte into shreg.
//  Push and pop in the same edge:
//   - Both take effect; count is unchanged.
//   - This applies when full too.
//   - A push into an empty FIFO is not popped until the next edge.
//  FSM states (baud counter counts 0..CLKS_PER_BIT-1; state advances on wrap):
//   - IDLE:  tx=1. Goes to START on pop.
//   - START: tx=0 for CLKS_PER_BIT cycles. Then DATA, bit=0.
//   - DATA:  tx=shreg[bit], LSB first, CLKS_PER_BIT cycles per bit.
//            After bit 7, goes to STOP.
//   - STOP:  tx=1 for CLKS_PER_BIT cycles. Then IDLE.
//  Frame timing:
//   - A frame is 10*CLKS_PER_BIT cycles.
//   - IDLE lasts at least 1 cycle between frames.
//   - Back-to-back frame gap = 1 cycle of tx=1 beyond the stop bit.
//  Latency: store at edge E into an empty FIFO with FSM idle:
//   - Pop at edge E+1.
//   - tx falls after edge E+1.
//  Output timing: tx is a registered output (no glitches); rdata and hit are combinational.
//  FIFO pointers wrap modulo FIFO_DEPTH.
//  Reset mid-frame: aborts at once; tx=1 after the reset edge; queued bytes discarded.
//  Other addresses: no state change; hit=0; rdata=0.
// TESTING
//  T1 reset, then read STATUS:
//   -> rdata=32'h0000_0004 (empty=1); tx=1 after reset.
//  T2 (CLKS_PER_BIT=4) store 0x55 to 0x1000:
//   -> tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
//   -> busy=1 for exactly 40 cycles.
//  T3 four stores 0x01..0x04 in 4 consecutive cycles:
//   -> four frames in order.
//   -> STATUS count reads 3 after the first pop; overflow stays 0.
//  T4 six rapid stores 0xA0..0xA5 while frame 0 is in flight:
//   -> 0xA5 rejected, overflow=1, full=1.
//   -> a store to 0x1004 clears overflow; frames 0xA0..0xA4 only.
//  T5 push when full in the same cycle as a pop:
//   -> push accepted, count stays 4, no overflow.
//  T6 reset asserted mid-DATA bit 3:
//   -> tx=1 and STATUS=0x4 next cycle; no further frames.
//   -> addr=0x0 leaves hit=0, rdata=0.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter that sits on the CPU data port beside
//   the data RAM. Stores to TXDATA queue bytes in a small FIFO. A serializer
//   drains the FIFO onto the tx line. STATUS is read combinationally, with the
//   same timing as the RAM read path.
//
//   Register map:
//     BASE_ADDR     TXDATA  (write: push wdata[7:0])
//     BASE_ADDR+4   STATUS  (read:  busy/full/empty/overflow/count;
//                            write: clear overflow, data ignored)
//
//   Ports:
//     clk    in   1   system clock, rising edge
//     reset  in   1   synchronous, active-high reset
//     addr   in   32  CPU data address
//     wdata  in   32  CPU store data; only [7:0] is used for TXDATA
//     we     in   1   CPU store strobe
//     hit    out  1   combinational: addr selects TXDATA or STATUS
//     rdata  out  32  combinational: STATUS word when addr is STATUS, else 0
//     tx     out  1   registered serial line, idle high
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int          CLKS_PER_BIT = 4,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic        hit,
   output logic [31:0] rdata,
   output logic        tx
);

   localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
   localparam int          PW          = $clog2(FIFO_DEPTH);
   localparam int          CW          = PW + 1;
   localparam int          BW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   // STATUS exposes a 4-bit count; deeper FIFOs report 15 once past it.
   function automatic logic [3:0] sat_count(input logic [CW-1:0] c);
      return (32'(c) > 32'd15) ? 4'hF : 4'(c);
   endfunction

   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          tx_q, tx_d;

   logic sel_data, sel_status;
   logic full, empty, busy;
   logic push_req, push, pop;
   logic baud_wrap;
   logic unused_wdata_hi;

   assign unused_wdata_hi = ^wdata[31:8];

   assign sel_data   = (addr == BASE_ADDR);
   assign sel_status = (addr == STATUS_ADDR);
   assign hit        = sel_data | sel_status;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);
   assign busy  = (state_q != S_IDLE);

   // A full FIFO still accepts a push on the edge that frees a slot.
   assign pop      = (state_q == S_IDLE) && !empty;
   assign push_req = we && sel_data;
   assign push     = push_req && (!full || pop);

   assign baud_wrap = (baud_q == BAUD_LAST);

   assign rdata = sel_status ? {24'h0, sat_count(count_q), ovf_q, empty, full, busy} : 32'h0;
   assign tx    = tx_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (push_req && !push)    ovf_d = 1'b1;
      else if (we && sel_status) ovf_d = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d = S_START;
               baud_d  = '0;
               shreg_d = fifo_q[rd_ptr_q];
            end
         end
         S_START: begin
            if (baud_wrap) begin
               state_d = S_DATA;
               baud_d  = '0;
               bit_d   = 3'd0;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_wrap) begin
               baud_d = '0;
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_STOP: begin
            if (baud_wrap) begin
               state_d = S_IDLE;
               baud_d  = '0;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      // tx is registered, so it is derived from the next state to line up
      // with the state register rather than lagging it by a cycle.
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shreg_d[bit_d];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= 3'd0;
         tx_q     <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
      end
   end

   // Byte storage carries no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= wdata[7:0];
      shreg_q <= shreg_d;
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE   = 32'h0000_1000;
   localparam logic [31:0] STAT   = 32'h0000_1004;
   localparam int          CPB    = 4;
   localparam int          FRAME  = 10 * CPB;
   localparam int          PERIOD = FRAME + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic        hit;
   logic [31:0] rdata;
   logic        tx;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];

   mmio_uart_tx #(
      .BASE_ADDR   (BASE),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .addr (addr),
      .wdata(wdata),
      .we   (we),
      .hit  (hit),
      .rdata(rdata),
      .tx   (tx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected line level k cycles after the first pop, for the bytes in
   // exp_q sent back to back (frame + one idle cycle each).
   function automatic logic exp_line(input int k);
      int f;
      int off;
      logic [7:0] b;
      if (k < 0) return 1'b1;
      f   = k / PERIOD;
      off = k % PERIOD;
      if (f >= exp_q.size()) return 1'b1;
      b = exp_q[f];
      if (off < CPB) return 1'b0;
      if (off < 9 * CPB) return b[3'((off - CPB) / CPB)];
      return 1'b1;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      we    = 1'b0;
      addr  = 32'h0;
      wdata = 32'h0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      addr = STAT;
      #1;
      checks++;
      if (rdata !== 32'h0000_0004) begin
         errors++;
         $display("FAIL reset_status got %h want %h", rdata, 32'h4);
      end
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx got %b want 1", tx);
      end
      checks++;
      if (hit !== 1'b1) begin
         errors++;
         $display("FAIL reset_hit_status got %b want 1", hit);
      end
      addr = BASE;
      #1;
      checks++;
      if (hit !== 1'b1 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_hit_data got hit=%b rdata=%h want hit=1 rdata=0", hit, rdata);
      end
   endtask

   task automatic test_single_frame();
      logic e;
      logic eb;
      do_reset();
      exp_q.delete();
      exp_q.push_back(8'h55);
      for (int c = 0; c < 46; c++) begin
         if (c == 0) begin
            we = 1'b1; addr = BASE; wdata = 32'h0000_0055;
         end
         tick();
         we = 1'b0; addr = STAT;
         #1;
         e  = exp_line(c - 1);
         eb = (c >= 1) && (c <= FRAME);
         checks++;
         if (tx !== e) begin
            errors++;
            $display("FAIL single_tx c=%0d got %b want %b", c, tx, e);
         end
         checks++;
         if (rdata[0] !== eb) begin
            errors++;
            $display("FAIL single_busy c=%0d got %b want %b", c, rdata[0], eb);
         end
         if (c == 0) begin
            checks++;
            if (rdata !== 32'h0000_0010) begin
               errors++;
               $display("FAIL single_queued got %h want %h", rdata, 32'h10);
            end
         end
      end
   endtask

   task automatic test_four_frames();
      logic e;
      do_reset();
      exp_q.delete();
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      for (int c = 0; c < 1 + 4 * PERIOD + 4; c++) begin
         if (c < 4) begin
            we = 1'b1; addr = BASE; wdata = 32'(c + 1);
         end
         tick();
         we = 1'b0; addr = STAT;
         #1;
         e = exp_line(c - 1);
         checks++;
         if (tx !== e) begin
            errors++;
            $display("FAIL four_tx c=%0d got %b want %b", c, tx, e);
         end
         if (c == 3) begin
            checks++;
            if (rdata !== 32'h0000_0031) begin
               errors++;
               $display("FAIL four_count got %h want %h", rdata, 32'h31);
            end
         end
      end
      checks++;
      if (rdata !== 32'h0000_0004) begin
         errors++;
         $display("FAIL four_final got %h want %h", rdata, 32'h4);
      end
   endtask

   task automatic test_overflow();
      logic e;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));
      for (int c = 0; c < 1 + 5 * PERIOD + 4; c++) begin
         if (c < 6) begin
            we = 1'b1; addr = BASE; wdata = 32'h0000_00A0 + 32'(c);
         end else if (c == 6) begin
            we = 1'b1; addr = STAT; wdata = 32'h0000_00FF;
         end
         tick();
         we = 1'b0; addr = STAT;
         #1;
         e = exp_line(c - 1);
         checks++;
         if (tx !== e) begin
            errors++;
            $display("FAIL ovf_tx c=%0d got %b want %b", c, tx, e);
         end
         if (c == 5) begin
            checks++;
            if (rdata !== 32'h0000_004B) begin
               errors++;
               $display("FAIL ovf_set got %h want %h", rdata, 32'h4B);
            end
         end
         if (c == 6) begin
            checks++;
            if (rdata !== 32'h0000_0043) begin
               errors++;
               $display("FAIL ovf_clear got %h want %h", rdata, 32'h43);
            end
         end
      end
   endtask

   task automatic test_full_push_pop();
      logic e;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 6; i++) exp_q.push_back(8'hB0 + 8'(i));
      for (int c = 0; c < 1 + 6 * PERIOD + 4; c++) begin
         if (c < 5) begin
            we = 1'b1; addr = BASE; wdata = 32'h0000_00B0 + 32'(c);
         end else if (c == 42) begin
            we = 1'b1; addr = BASE; wdata = 32'h0000_00B5;
         end
         tick();
         we = 1'b0; addr = STAT;
         #1;
         e = exp_line(c - 1);
         checks++;
         if (tx !== e) begin
            errors++;
            $display("FAIL fullpp_tx c=%0d got %b want %b", c, tx, e);
         end
         if (c == 41) begin
            checks++;
            if (rdata !== 32'h0000_0042) begin
               errors++;
               $display("FAIL fullpp_before got %h want %h", rdata, 32'h42);
            end
         end
         if (c == 42) begin
            checks++;
            if (rdata !== 32'h0000_0043) begin
               errors++;
               $display("FAIL fullpp_after got %h want %h", rdata, 32'h43);
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic e;
      do_reset();
      exp_q.delete();
      exp_q.push_back(8'hF0);
      for (int c = 0; c < 18; c++) begin
         if (c == 0) begin
            we = 1'b1; addr = BASE; wdata = 32'h0000_00F0;
         end else if (c == 1) begin
            we = 1'b1; addr = BASE; wdata = 32'h0000_000F;
         end
         tick();
         we = 1'b0; addr = STAT;
         #1;
         e = exp_line(c - 1);
         checks++;
         if (tx !== e) begin
            errors++;
            $display("FAIL midrst_tx c=%0d got %b want %b", c, tx, e);
         end
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1 || rdata !== 32'h0000_0004) begin
         errors++;
         $display("FAIL midrst_after got tx=%b rdata=%h want tx=1 rdata=4", tx, rdata);
      end
      for (int c = 0; c < 120; c++) begin
         tick();
         checks++;
         if (tx !== 1'b1) begin
            errors++;
            $display("FAIL midrst_quiet c=%0d got %b want 1", c, tx);
         end
      end
      checks++;
      if (rdata !== 32'h0000_0004) begin
         errors++;
         $display("FAIL midrst_status got %h want %h", rdata, 32'h4);
      end
   endtask

   task automatic test_other_addr();
      addr = 32'h0;
      #1;
      checks++;
      if (hit !== 1'b0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL other_zero got hit=%b rdata=%h want hit=0 rdata=0", hit, rdata);
      end
      we = 1'b1; addr = 32'h0000_1008; wdata = 32'h0000_0077;
      #1;
      checks++;
      if (hit !== 1'b0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL other_1008 got hit=%b rdata=%h want hit=0 rdata=0", hit, rdata);
      end
      tick();
      we = 1'b0; addr = STAT;
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++;
         if (tx !== 1'b1) begin
            errors++;
            $display("FAIL other_tx c=%0d got %b want 1", c, tx);
         end
      end
      checks++;
      if (rdata !== 32'h0000_0004) begin
         errors++;
         $display("FAIL other_status got %h want %h", rdata, 32'h4);
      end
   endtask

   initial begin
      reset = 1'b1;
      we    = 1'b0;
      addr  = 32'h0;
      wdata = 32'h0;
      test_reset();
      test_single_frame();
      test_four_frames();
      test_overflow();
      test_full_push_pop();
      test_reset_mid_frame();
      test_other_addr();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
